// File: rtl/mem_bus_master.sv
// Load/store bus master: lane steering, sign/zero extension and pipelined reads with
// in-order responses on an Avalon-MM-style bus.
module mem_bus_master #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_err,
    output logic                busy,
    output logic [31:0]         avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    function automatic logic size_legal(input logic [1:0] size, input logic [2:0] addr);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return addr[0] == 1'b0;
            2'b10:   return addr[1:0] == 2'b00;
            default: return (DATA_W == 64) && (addr == 3'b000);
        endcase
    endfunction

    function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off);
        logic [15:0] m;
        case (size)
            2'b00:   m = 16'h0001;
            2'b01:   m = 16'h0003;
            2'b10:   m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        return BE_W'(m << off);
    endfunction

    function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] rdata,
                                                      input logic [OFF_W-1:0]  off,
                                                      input logic [1:0]        size,
                                                      input logic              sgn);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] keep;
        logic              neg;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   begin keep = DATA_W'(8'hFF);         neg = sh[7];  end
            2'b01:   begin keep = DATA_W'(16'hFFFF);      neg = sh[15]; end
            2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); neg = sh[31]; end
            default: begin keep = '1;                     neg = 1'b0;   end
        endcase
        return (sh & keep) | ((sgn && neg) ? ~keep : '0);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic              cmd_valid;
    logic              cmd_write;
    logic [1:0]        cmd_size;
    logic              cmd_signed;
    logic [31:0]       cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [TAG_W-1:0]  cmd_tag;

    logic [TAG_W-1:0]  fifo_tag    [MAX_OUT];
    logic [OFF_W-1:0]  fifo_off    [MAX_OUT];
    logic [1:0]        fifo_size   [MAX_OUT];
    logic              fifo_signed [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  outstanding;

    logic             cmd_legal;
    logic [OFF_W-1:0] cmd_off;
    logic             drained;
    logic             accept;
    logic             fast_err;
    logic             push;
    logic             pop;
    logic             wr_done;
    logic             err_done;

    assign cmd_legal = size_legal(cmd_size, cmd_addr[2:0]);
    assign cmd_off   = cmd_addr[OFF_W-1:0];
    assign drained   = (outstanding == '0);

    assign req_ready = !cmd_valid;
    assign busy      = cmd_valid || !drained;

    assign avm_read  = cmd_valid && !cmd_write && cmd_legal && (outstanding < CNT_W'(MAX_OUT));
    // Stores wait for reads to drain so responses stay in issue order.
    assign avm_write = cmd_valid && cmd_write && cmd_legal && drained;

    assign avm_address    = {cmd_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign avm_byteenable = (avm_read || avm_write) ? lane_mask(cmd_size, cmd_off) : '0;
    assign avm_writedata  = cmd_wdata << {cmd_off, 3'b000};

    assign accept   = req_valid && req_ready;
    // An illegal request arriving with nothing in flight is answered straight from the input.
    assign fast_err = accept && !size_legal(req_size, req_addr[2:0]) && drained;
    assign push     = avm_read && !avm_waitrequest;
    assign pop      = avm_readdatavalid && !drained;
    assign wr_done  = avm_write && !avm_waitrequest;
    assign err_done = cmd_valid && !cmd_legal && drained;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid   <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_size    <= '0;
            cmd_signed  <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_tag     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
        end else begin
            if (accept) begin
                cmd_valid  <= !fast_err;
                cmd_write  <= req_write;
                cmd_size   <= req_size;
                cmd_signed <= req_signed;
                cmd_addr   <= req_addr;
                cmd_wdata  <= req_wdata;
                cmd_tag    <= req_tag;
            end else if (push || wr_done || err_done) begin
                cmd_valid <= 1'b0;
            end

            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      outstanding <= outstanding + CNT_W'(1);
            else if (pop && !push) outstanding <= outstanding - CNT_W'(1);

            rsp_valid <= 1'b0;
            if (pop) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_tag   <= fifo_tag[rd_ptr];
                rsp_data  <= format_load(avm_readdata, fifo_off[rd_ptr], fifo_size[rd_ptr],
                                         fifo_signed[rd_ptr]);
            end else if (wr_done || err_done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_done;
                rsp_tag   <= cmd_tag;
                rsp_data  <= '0;
            end else if (fast_err) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_tag   <= req_tag;
                rsp_data  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tag[wr_ptr]    <= cmd_tag;
            fifo_off[wr_ptr]    <= cmd_off;
            fifo_size[wr_ptr]   <= cmd_size;
            fifo_signed[wr_ptr] <= cmd_signed;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: byte-addressed memory model, randomised Avalon slave and an
// in-order expected-response queue computed from the architectural load/store rules.
module tb_mem_bus_master;
    logic        clk;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [3:0]  avm_byteenable;

    mem_bus_master #(.DATA_W(32), .MAX_OUT(4), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    typedef struct { logic [4:0] tag; logic err; logic [31:0] data; int acc; } exp_t;
    typedef struct { int due; logic [31:0] data; } ret_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] ref_mem [0:4095];
    logic [7:0] bus_mem [0:4095];
    exp_t exp_q[$];
    ret_t ret_q[$];

    // slave knobs and observations
    int lat_min = 1, lat_max = 1, wr_pct = 0, force_wait = 0;
    int reads = 0, stall_cycles = 0, inflight = 0, max_inflight = 0, last_due = 0;
    int hold_viol = 0, both_viol = 0;
    logic        hold_prev = 1'b0;
    logic [37:0] hold_val;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
    logic [3:0]  last_rd_be, last_wr_be;

    // response observations
    int rsp_count = 0, last_lat = 0;
    logic [31:0] last_data;
    logic [4:0]  last_tag;
    logic        last_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural result of one request; stores update the reference memory.
    function automatic exp_t model_req(input logic wr, input logic [1:0] sz, input logic sg,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       input logic [4:0] tg);
        exp_t e;
        int n;
        logic [31:0] v;
        e.tag = tg; e.err = 1'b0; e.data = '0; e.acc = 0;
        n = 1 << sz;
        if (sz == 2'd3 || (a % n) != 0) begin
            e.err = 1'b1;
            return e;
        end
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[(a + i) & 4095] = wd[8*i +: 8];
            return e;
        end
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) & 4095];
        if (sg && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        e.data = v;
        return e;
    endfunction

    task automatic poke_word(input int a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            ref_mem[a + i] = v[8*i +: 8];
            bus_mem[a + i] = v[8*i +: 8];
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_tag = tg;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_eq("req_accept_timeout", 1, 0);
            req_valid = 1'b0;
            return;
        end
        e = model_req(wr, sz, sg, a, wd, tg);
        e.acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_eq("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Avalon slave: decides waitrequest for the coming edge and models in-order read latency.
    always @(negedge clk) begin
        int base, lat;
        logic [31:0] d;
        ret_t r;
        if (reset_n) begin
            if (avm_read && avm_write) both_viol++;
            if (hold_prev && ({avm_read, avm_write, avm_address, avm_byteenable} !== hold_val))
                hold_viol++;
        end
        hold_prev = 1'b0;

        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata = r.data;
            if (inflight > 0) inflight--;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = $urandom;
        end

        if (reset_n && (avm_read || avm_write)) begin
            if (force_wait > 0) begin
                avm_waitrequest = 1'b1;
                force_wait--;
            end else begin
                avm_waitrequest = ($urandom_range(0, 99) < wr_pct);
            end
            base = int'({avm_address[11:2], 2'b00});
            if (avm_waitrequest) begin
                hold_prev = 1'b1;
                hold_val = {avm_read, avm_write, avm_address, avm_byteenable};
                if (avm_read) stall_cycles++;
            end else if (avm_read) begin
                for (int k = 0; k < 4; k++) d[8*k +: 8] = bus_mem[base + k];
                lat = $urandom_range(lat_min, lat_max);
                r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                r.data = d;
                last_due = r.due;
                ret_q.push_back(r);
                reads++;
                inflight++;
                if (inflight > max_inflight) max_inflight = inflight;
                last_rd_addr = avm_address;
                last_rd_be = avm_byteenable;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (avm_byteenable[k]) bus_mem[base + k] = avm_writedata[8*k +: 8];
                last_wr_addr = avm_address;
                last_wr_be = avm_byteenable;
                last_wr_data = avm_writedata;
            end
        end else begin
            avm_waitrequest = ($urandom_range(0, 99) < wr_pct);
        end
    end

    // Response checker against the in-order expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && rsp_valid) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rsp_tag", rsp_tag, e.tag);
                check_eq("rsp_err", rsp_err, e.err);
                check_eq("rsp_data", rsp_data, e.data);
                last_lat = cyc - e.acc;
                last_data = rsp_data;
                last_tag = rsp_tag;
                last_err = rsp_err;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, st0, rc0, n;
        logic [1:0]  sz;
        logic [31:0] a;

        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; req_tag = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_tag, rsp_data}, 0);
        check_eq("rst_strobes", {avm_read, avm_write}, 0);
        check_eq("rst_bus", {avm_address, avm_byteenable, avm_writedata}, 0);
        reset_n = 1'b1;

        // LB sign-extend
        poke_word(32'h100, 32'h80FF_FF00);
        lat_min = 3; lat_max = 3;
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7);
        drain();
        check_eq("lb_addr", last_rd_addr, 32'h100);
        check_eq("lb_be", last_rd_be, 4'b1000);
        check_eq("lb_data", last_data, 32'hFFFF_FF80);
        check_eq("lb_tag", last_tag, 5'd7);
        check_eq("lb_latency", last_lat, 5);

        // SH lane shift, then read back
        do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, 5'd3);
        drain();
        check_eq("sh_addr", last_wr_addr, 32'h200);
        check_eq("sh_be", last_wr_be, 4'b1100);
        check_eq("sh_wdata_hi", last_wr_data[31:16], 16'hBEEF);
        check_eq("sh_err", last_err, 0);
        check_eq("sh_latency", last_lat, 2);
        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd4);
        drain();

        // Pipelining up to the outstanding limit
        lat_min = 12; lat_max = 12; max_inflight = 0;
        for (int t = 0; t < 6; t++) do_req(1'b0, 2'd2, 1'b0, 32'h40 + 4 * t, 32'h0, 5'(t));
        drain();
        check_eq("pipe_max_inflight", max_inflight, 4);
        check_eq("pipe_busy_after", busy, 0);

        // Waitrequest stall
        poke_word(32'h300, 32'h1234_8001);
        lat_min = 2; lat_max = 2;
        rd0 = reads; st0 = stall_cycles; force_wait = 3;
        do_req(1'b0, 2'd1, 1'b0, 32'h300, 32'h0, 5'd9);
        drain();
        check_eq("stall_cycles", stall_cycles - st0, 3);
        check_eq("stall_one_push", reads - rd0, 1);
        check_eq("stall_data", last_data, 32'h0000_8001);

        // Error ordering behind an outstanding read
        lat_min = 8; lat_max = 8; rd0 = reads;
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h402, 32'h0, 5'd2);
        do_req(1'b0, 2'd3, 1'b0, 32'h408, 32'h0, 5'd3);
        drain();
        check_eq("err_no_bus_read", reads - rd0, 1);
        do_req(1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 5'd5);
        drain();
        check_eq("err_idle_latency", last_lat, 1);
        check_eq("err_idle_flag", last_err, 1);

        // Randomised mix
        lat_min = 1; lat_max = 6; wr_pct = 25;
        for (int i = 0; i < 150; i++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            do_req($urandom_range(0, 9) < 4, sz, 1'($urandom), a, $urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();
        wr_pct = 0;

        // Reset with reads outstanding and a read stalled on the bus
        lat_min = 20; lat_max = 20; rc0 = rsp_count;
        do_req(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd10);
        do_req(1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 5'd11);
        n = 0;
        while (inflight < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_two_inflight", inflight, 2);
        force_wait = 100;
        do_req(1'b0, 2'd2, 1'b0, 32'h508, 32'h0, 5'd12);
        @(negedge clk);
        check_eq("pre_rst_read", avm_read, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_ready_busy", {req_ready, busy}, 2'b10);
        check_eq("async_rst_strobes", {avm_read, avm_write, avm_byteenable}, 0);
        check_eq("async_rst_addr", avm_address, 0);
        check_eq("async_rst_rsp", {rsp_valid, rsp_err, rsp_tag, rsp_data}, 0);
        exp_q.delete();
        force_wait = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (ret_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq("stale_returns_done", ret_q.size(), 0);
        check_eq("stale_no_rsp", rsp_count - rc0, 0);
        check_eq("stale_not_busy", busy, 0);
        lat_min = 2; lat_max = 2;
        do_req(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd13);
        drain();
        check_eq("post_rst_tag", last_tag, 5'd13);

        check_eq("strobe_hold", hold_viol, 0);
        check_eq("strobe_both", both_viol, 0);
        check_eq("exp_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
